// File: rtl/fsm_updown_counter_param_pkg.sv
// ---------------------------------------------------------------------------
// fsm_updown_counter_param_pkg : shared FSM state encodings and mode constants
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fsm_updown_counter_param_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_UP      = 2'b01,
    ST_DOWN    = 2'b10,
    ST_ILLEGAL = 2'b11
  } dir_state_e;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

endpackage

`default_nettype wire

// File: rtl/fsm_updown_counter_param_if.sv
// ---------------------------------------------------------------------------
// fsm_updown_counter_param_if : command and status bundle of the counter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface fsm_updown_counter_param_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             down;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic [1:0]       dir;
  logic             at_max;
  logic             at_min;
  logic             ovf;
  logic             unf;

  modport master (
    output en, up, down, load, load_val,
    input  count, dir, at_max, at_min, ovf, unf
  );

  modport slave (
    input  en, up, down, load, load_val,
    output count, dir, at_max, at_min, ovf, unf
  );
endinterface

`default_nettype wire

// File: rtl/fsm_counter_dir_ctrl.sv
// ---------------------------------------------------------------------------
// fsm_counter_dir_ctrl : 2-bit direction FSM (IDLE / UP / DOWN)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fsm_counter_dir_ctrl
  import fsm_updown_counter_param_pkg::*;
(
  input  wire        clk,
  input  wire        rst,
  input  wire        up_i,
  input  wire        down_i,
  output dir_state_e state_o
);

  dir_state_e state_q;
  dir_state_e state_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // No command keeps the latched direction; the unused 11 code falls back to IDLE.
  always_comb begin
    state_d = state_q;
    case ({up_i, down_i})
      2'b10:   state_d = ST_UP;
      2'b01:   state_d = ST_DOWN;
      2'b11:   state_d = ST_IDLE;
      default: begin
        if (state_q == ST_ILLEGAL) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  assign state_o = state_q;

endmodule

`default_nettype wire

// File: rtl/fsm_updown_counter_param.sv
// ---------------------------------------------------------------------------
// fsm_updown_counter_param : parametrised up/down counter with wrap or saturate
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fsm_updown_counter_param
  import fsm_updown_counter_param_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 2**WIDTH - 1,
  parameter int RST_VAL  = 0,
  parameter int SATURATE = MODE_WRAP
) (
  input  wire                         clk,
  input  wire                         rst,
  fsm_updown_counter_param_if.slave   bus
);

  localparam logic [WIDTH-1:0] MAX_C = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_C = RST_VAL[WIDTH-1:0];

  dir_state_e       dir_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             unf_q;
  logic             unf_d;

  fsm_counter_dir_ctrl u_dir_ctrl (
    .clk     (clk),
    .rst     (rst),
    .up_i    (bus.up),
    .down_i  (bus.down),
    .state_o (dir_q)
  );

  // Stepping follows the registered direction, so a new command steps one edge later.
  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (bus.load) begin
      count_d = (bus.load_val > MAX_C) ? MAX_C : bus.load_val;
    end else if (bus.en) begin
      case (dir_q)
        ST_UP: begin
          if (count_q != MAX_C) begin
            count_d = count_q + 1'b1;
          end else if (SATURATE == MODE_WRAP) begin
            count_d = '0;
            ovf_d   = 1'b1;
          end
        end
        ST_DOWN: begin
          if (count_q != '0) begin
            count_d = count_q - 1'b1;
          end else if (SATURATE == MODE_WRAP) begin
            count_d = MAX_C;
            unf_d   = 1'b1;
          end
        end
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= RST_C;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.count  = count_q;
  assign bus.dir    = dir_q;
  assign bus.at_max = (count_q == MAX_C);
  assign bus.at_min = (count_q == '0);
  assign bus.ovf    = ovf_q;
  assign bus.unf    = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_fsm_updown_counter_param.sv
// ---------------------------------------------------------------------------
// tb_fsm_updown_counter_param : directed self-checking bench, three instances
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fsm_updown_counter_param;
  import fsm_updown_counter_param_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, up = 1'b0, down = 1'b0, load = 1'b0;
  logic [3:0] load_val = 4'd0;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  // b0: wrap, MAX 15; b1: saturate, MAX 15; b2: wrap, MAX 9, reset value 3
  fsm_updown_counter_param_if #(.WIDTH(4)) b0 ();
  fsm_updown_counter_param_if #(.WIDTH(4)) b1 ();
  fsm_updown_counter_param_if #(.WIDTH(4)) b2 ();

  assign b0.en = en;  assign b0.up = up;  assign b0.down = down;  assign b0.load = load;  assign b0.load_val = load_val;
  assign b1.en = en;  assign b1.up = up;  assign b1.down = down;  assign b1.load = load;  assign b1.load_val = load_val;
  assign b2.en = en;  assign b2.up = up;  assign b2.down = down;  assign b2.load = load;  assign b2.load_val = load_val;

  fsm_updown_counter_param #(.WIDTH(4), .MAX_VAL(15), .RST_VAL(0), .SATURATE(MODE_WRAP))
    u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  fsm_updown_counter_param #(.WIDTH(4), .MAX_VAL(15), .RST_VAL(0), .SATURATE(MODE_SAT))
    u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  fsm_updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .RST_VAL(3), .SATURATE(MODE_WRAP))
    u2 (.clk(clk), .rst(rst), .bus(b2.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #2;
    n_checks++;
    if ({b0.count, b0.dir, b0.at_max, b0.at_min, b0.ovf, b0.unf} !== {4'd0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_u0: got cnt=%0d dir=%0d max=%0b min=%0b ovf=%0b unf=%0b, want 0 0 0 1 0 0",
               b0.count, b0.dir, b0.at_max, b0.at_min, b0.ovf, b0.unf);
    end
    n_checks++;
    if ({b2.count, b2.at_min, b2.at_max} !== {4'd3, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_u2: got cnt=%0d min=%0b max=%0b, want 3 0 0", b2.count, b2.at_min, b2.at_max);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if ({b0.count, b0.dir} !== {4'd0, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_release_idle: got cnt=%0d dir=%0d, want 0 0", b0.count, b0.dir);
    end
  endtask

  task automatic test_count_up_wrap();
    logic [3:0] e0, e1, e2;
    up = 1'b1;
    en = 1'b1;
    tick();
    n_checks++;
    if ({b0.count, b0.dir, b2.count} !== {4'd0, 2'b01, 4'd3}) begin
      n_fail++;
      $display("FAIL up_first_edge: got cnt0=%0d dir=%0d cnt2=%0d, want 0 1 3", b0.count, b0.dir, b2.count);
    end
    for (int i = 1; i <= 17; i++) begin
      tick();
      e0 = 4'(i % 16);
      e1 = (i > 15) ? 4'd15 : 4'(i);
      e2 = 4'((3 + i) % 10);
      n_checks++;
      if ({b0.count, b0.ovf, b0.at_max, b0.unf} !== {e0, (i == 16), (e0 == 4'd15), 1'b0}) begin
        n_fail++;
        $display("FAIL up_wrap_u0 step %0d: got cnt=%0d ovf=%0b max=%0b unf=%0b, want cnt=%0d ovf=%0b max=%0b unf=0",
                 i, b0.count, b0.ovf, b0.at_max, b0.unf, e0, (i == 16), (e0 == 4'd15));
      end
      n_checks++;
      if ({b1.count, b1.ovf} !== {e1, 1'b0}) begin
        n_fail++;
        $display("FAIL up_sat_u1 step %0d: got cnt=%0d ovf=%0b, want cnt=%0d ovf=0", i, b1.count, b1.ovf, e1);
      end
      n_checks++;
      if ({b2.count, b2.ovf, b2.at_max} !== {e2, (e2 == 4'd0), (e2 == 4'd9)}) begin
        n_fail++;
        $display("FAIL up_max9_u2 step %0d: got cnt=%0d ovf=%0b max=%0b, want cnt=%0d ovf=%0b max=%0b",
                 i, b2.count, b2.ovf, b2.at_max, e2, (e2 == 4'd0), (e2 == 4'd9));
      end
    end
  endtask

  task automatic test_load_clamp();
    load = 1'b1;
    load_val = 4'd12;
    tick();
    n_checks++;
    if ({b2.count, b2.ovf, b0.count, b0.ovf, b0.dir} !== {4'd9, 1'b0, 4'd12, 1'b0, 2'b01}) begin
      n_fail++;
      $display("FAIL load_clamp: got cnt2=%0d ovf2=%0b cnt0=%0d ovf0=%0b dir0=%0d, want 9 0 12 0 1",
               b2.count, b2.ovf, b0.count, b0.ovf, b0.dir);
    end
  endtask

  task automatic test_count_down_wrap();
    logic [3:0] e0, e2;
    load_val = 4'd0;
    up = 1'b0;
    down = 1'b1;
    tick();
    n_checks++;
    if ({b0.count, b0.dir, b0.unf, b2.count, b2.unf} !== {4'd0, 2'b10, 1'b0, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL down_load_zero: got cnt0=%0d dir=%0d unf0=%0b cnt2=%0d unf2=%0b, want 0 2 0 0 0",
               b0.count, b0.dir, b0.unf, b2.count, b2.unf);
    end
    load = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      e0 = 4'((16 - i) % 16);
      e2 = 4'((10 - i) % 10);
      n_checks++;
      if ({b0.count, b0.unf, b0.ovf} !== {e0, (i == 1), 1'b0}) begin
        n_fail++;
        $display("FAIL down_wrap_u0 step %0d: got cnt=%0d unf=%0b ovf=%0b, want cnt=%0d unf=%0b ovf=0",
                 i, b0.count, b0.unf, b0.ovf, e0, (i == 1));
      end
      n_checks++;
      if ({b1.count, b1.unf, b1.at_min} !== {4'd0, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL down_sat_u1 step %0d: got cnt=%0d unf=%0b min=%0b, want 0 0 1", i, b1.count, b1.unf, b1.at_min);
      end
      n_checks++;
      if ({b2.count, b2.unf} !== {e2, (i == 1)}) begin
        n_fail++;
        $display("FAIL down_wrap_u2 step %0d: got cnt=%0d unf=%0b, want cnt=%0d unf=%0b", i, b2.count, b2.unf, e2, (i == 1));
      end
    end
  endtask

  task automatic test_conflict_idle();
    load = 1'b1;
    load_val = 4'd5;
    up = 1'b1;
    down = 1'b0;
    tick();
    n_checks++;
    if ({b0.count, b0.dir} !== {4'd5, 2'b01}) begin
      n_fail++;
      $display("FAIL conflict_setup: got cnt=%0d dir=%0d, want 5 1", b0.count, b0.dir);
    end
    load = 1'b0;
    down = 1'b1;
    tick();
    n_checks++;
    if ({b0.count, b0.dir} !== {4'd6, 2'b00}) begin
      n_fail++;
      $display("FAIL conflict_edge: got cnt=%0d dir=%0d, want 6 0", b0.count, b0.dir);
    end
    up = 1'b0;
    down = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if ({b0.count, b0.dir} !== {4'd6, 2'b00}) begin
        n_fail++;
        $display("FAIL conflict_hold cycle %0d: got cnt=%0d dir=%0d, want 6 0", i, b0.count, b0.dir);
      end
    end
  endtask

  task automatic test_enable_hold();
    up = 1'b1;
    tick();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({b0.count, b0.dir} !== {4'd6, 2'b01}) begin
        n_fail++;
        $display("FAIL en_low_hold cycle %0d: got cnt=%0d dir=%0d, want 6 1", i, b0.count, b0.dir);
      end
    end
    load = 1'b1;
    load_val = 4'd3;
    tick();
    n_checks++;
    if ({b0.count, b0.dir} !== {4'd3, 2'b01}) begin
      n_fail++;
      $display("FAIL load_en_low: got cnt=%0d dir=%0d, want 3 1", b0.count, b0.dir);
    end
    load = 1'b0;
    en = 1'b1;
    tick();
    n_checks++;
    if (b0.count !== 4'd4) begin
      n_fail++;
      $display("FAIL en_resume: got cnt=%0d, want 4", b0.count);
    end
  endtask

  task automatic test_async_reset();
    tick();
    #3 rst = 1'b0;
    #1;
    n_checks++;
    if ({b0.count, b0.dir, b0.ovf, b0.unf, b2.count, b2.dir} !== {4'd0, 2'b00, 1'b0, 1'b0, 4'd3, 2'b00}) begin
      n_fail++;
      $display("FAIL async_reset: got cnt0=%0d dir0=%0d ovf=%0b unf=%0b cnt2=%0d dir2=%0d, want 0 0 0 0 3 0",
               b0.count, b0.dir, b0.ovf, b0.unf, b2.count, b2.dir);
    end
    up = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({b0.count, b0.dir} !== {4'd0, 2'b00}) begin
        n_fail++;
        $display("FAIL post_reset_idle cycle %0d: got cnt=%0d dir=%0d, want 0 0", i, b0.count, b0.dir);
      end
    end
    up = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({b0.count, b0.dir} !== {4'd1, 2'b01}) begin
      n_fail++;
      $display("FAIL post_reset_resume: got cnt=%0d dir=%0d, want 1 1", b0.count, b0.dir);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_count_up_wrap();
    test_load_clamp();
    test_count_down_wrap();
    test_conflict_idle();
    test_enable_hold();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fsm_updown_counter_param.md
Name: fsm_updown_counter_param

Overview:
Parametrised successor to the 2-bit up/down FSM counter.
- Generalised to WIDTH bits, with a programmable terminal value and a selectable wrap or saturate mode.
- Adds synchronous load, count enable, terminal-value flags and overflow/underflow pulses.
- Sits in the day-7 counter FSM area as the reusable event/position counter. Multiple instances share one clock and reset.

Parameters:
- WIDTH, 4, counter width in bits (legal range 2..16).
- MAX_VAL, 2**WIDTH-1, upper terminal value. Count range is 0..MAX_VAL. Must be at least 1.
- RST_VAL, 0, count value after reset. Must be at most MAX_VAL.
- SATURATE, 0, terminal behaviour. 0 = wrap-around, 1 = saturate (hold at the terminal value).

Ports:
- clk, in, 1, system clock, rising edge.
- rst, in, 1, asynchronous active-low reset.
- en, in, 1, count enable. Gates stepping only; does not gate FSM transitions or load.
- up, in, 1, direction command: count up.
- down, in, 1, direction command: count down.
- load, in, 1, synchronous load strobe.
- load_val, in, WIDTH, value to load.
- count, out, WIDTH, current count (registered).
- dir, out, 2, FSM state: 00 = IDLE, 01 = UP, 10 = DOWN (registered).
- at_max, out, 1, high when count == MAX_VAL (combinational from count).
- at_min, out, 1, high when count == 0 (combinational from count).
- ovf, out, 1, one-cycle pulse on wrap from MAX_VAL to 0 (registered).
- unf, out, 1, one-cycle pulse on wrap from 0 to MAX_VAL (registered).

Behaviour:
- Reset (rst = 0, asynchronous, takes effect immediately at any time):
  - count = RST_VAL, dir = IDLE, ovf = 0, unf = 0.
  - at_max and at_min follow count, so with RST_VAL = 0, at_min = 1.
  - Reset release is synchronous to clk. The first active edge follows the rules below.
- FSM (next state evaluated every edge, independent of en):
  - up=1, down=0 -> UP.
  - up=0, down=1 -> DOWN.
  - up=1, down=1 -> IDLE (conflicting command stops counting).
  - up=0, down=0 -> retain current state (direction is latched).
  - State 11 is illegal and recovers to IDLE on the next edge.
- Counting uses the registered state, not the inputs:
  - One cycle of latency from a command to the first step. A command sampled at edge N changes dir at N; the first step occurs at edge N+1 if en = 1.
  - IDLE, or en = 0: count holds.
  - UP, count < MAX_VAL: count + 1.
  - UP, count == MAX_VAL, SATURATE = 0: count -> 0 and ovf = 1 for one cycle.
  - UP, count == MAX_VAL, SATURATE = 1: count holds at MAX_VAL, ovf stays 0.
  - DOWN, count > 0: count - 1.
  - DOWN, count == 0, SATURATE = 0: count -> MAX_VAL and unf = 1 for one cycle.
  - DOWN, count == 0, SATURATE = 1: count holds at 0, unf stays 0.
- Load:
  - load has priority over stepping and en, and does not alter dir.
  - count <= load_val if load_val <= MAX_VAL, otherwise count <= MAX_VAL (clamp).
  - No ovf/unf pulse is generated on a load edge.
- Pulses: ovf and unf are never high together, and each is low in every cycle without a wrap.
- Arithmetic: next-value logic is computed in WIDTH bits. With MAX_VAL < 2**WIDTH-1, values above MAX_VAL are unreachable except via the clamp.

Decomposition:
- Shared header fsm_counter_defs.vh containing:
  - state encodings ST_IDLE = 2'b00, ST_UP = 2'b01, ST_DOWN = 2'b10;
  - mode constants MODE_WRAP = 0, MODE_SAT = 1.
- One natural sub-module, fsm_counter_dir_ctrl: the 2-bit direction FSM (inputs clk, rst, up, down; output state).
- The datapath (count, flags, pulses) stays in the top module.

Test Plan:
- Reset then up=1 held, en=1 (WIDTH=4, default MAX_VAL):
  - count 0 at the first edge (dir becomes UP), then 1, 2, ... 15, 0.
  - ovf high exactly in the cycle count shows 0.
  - at_max high only at 15.
- down=1 held from count=0, SATURATE=0 -> count 15, 14, ..., with unf pulsed on the 0 -> 15 step. Second instance with SATURATE=1 holds at 0 with unf = 0.
- MAX_VAL=9, counting up -> 8, 9, 0 with ovf. load=1 with load_val=12 -> count=9 next cycle, no ovf.
- In UP at count=5: raise up and down together for one cycle, then drop both -> dir=IDLE, count frozen at 6 (the one in-flight step completes), stays 6 for 5 cycles.
- In UP with en=0 for 3 cycles -> count holds. Then assert load=1 with load_val=3 and en=0 -> count=3.
- Assert rst=0 asynchronously mid-cycle during counting -> count=RST_VAL and dir=IDLE before the next clk edge, ovf=0. After release, counting resumes only after a new up command.
